droute_xbar: RTL and testbench
==============================

# droute_xbar

Parametrised AXI-Stream crossbar that routes NUM_IN input streams to NUM_OUT output streams under a per-output source-select configuration. It generalises the fixed two-switch router to arbitrary port counts and data width. It adds packet-safe reconfiguration, one-to-many broadcast with joint backpressure, and a registered two-entry skid buffer on every output. It sits between the width converters and the compute-array/DMA ports in the data-route layer.

## Interface
- NUM_IN, 5, number of input streams (2..16)
- NUM_OUT, 8, number of output streams (1..16)
- DWIDTH, 1536, tdata width of every stream
- SEL_W, $clog2(NUM_IN)+1, per-output select field: MSB = enable, low bits = input index
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_route  in  NUM_OUT*SEL_W  requested routing; field o selects the source of output o
- cfg_valid  in  1  request to apply cfg_route; hold with cfg_route stable until cfg_ready
- cfg_ready  out  1  one-cycle pulse when the new routing becomes active
- s_tdata  in  NUM_IN*DWIDTH  input data, lane i at [i*DWIDTH +: DWIDTH]
- s_tvalid / s_tlast  in  NUM_IN  per-input valid / last
- s_tready  out  NUM_IN  per-input ready
- m_tdata  out  NUM_OUT*DWIDTH  output data
- m_tvalid / m_tlast  out  NUM_OUT  per-output valid / last
- m_tready  in  NUM_OUT  per-output ready
- busy  out  1  high when any skid holds data or any input is mid-packet

## Operation
- Active route register act_route. A field is "routed" when en=1 and idx<NUM_IN; otherwise the output is disconnected (idx>=NUM_IN is treated as disabled).
- Input i transfer (fire_i) = s_tvalid[i] & s_tready[i].
- s_tready[i] = gate_i & AND over every output o routed from i of skid_o.not_full.
- s_tready[i] = 0 if no output is routed from i. Unrouted inputs stall; they never drop data.
- Broadcast: on fire_i, the beat (tdata, tlast) is written into every routed skid simultaneously. All routed skids take the beat, or none does.
- Per input, an in_pkt flag is set on fire with tlast=0 and cleared on fire with tlast=1.
- Each output has a two-entry skid FIFO with registered outputs; m_* are driven from the head entry. not_full = fewer than 2 entries. An entry is popped on m_tvalid & m_tready.
- FSM states RUN, DRAIN, SWAP:
  - RUN: gate_i=1 for all i. cfg_valid=1 -> DRAIN.
  - DRAIN: gate_i = in_pkt_i, so open packets finish and new packets are held. When all in_pkt=0 and all skids are empty -> SWAP.
  - SWAP (1 cycle): act_route <= cfg_route, cfg_ready=1, gate_i=0 -> RUN.
- cfg_valid deasserted during DRAIN: the FSM still completes the swap with the cfg_route value sampled in SWAP. Deasserting it early is illegal stimulus.

## Timing
- Reset values: act_route=0 (all disconnected), FSM=RUN, skids empty, in_pkt=0. Outputs: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, cfg_ready=0, busy=0.
- Reset asserted mid-operation clears all buffered beats immediately; the loss is accepted by design.
- Latency: input fire in cycle t -> m_tvalid in cycle t+1.
- Throughput: 1 beat/cycle per route with m_tready held high. A stalled output sustains full rate after it releases, with no bubble (2-entry skid).
- s_tready is combinational from skid occupancy and FSM state only. It never depends on s_tvalid.
- Simultaneous push and pop on a full skid: the pop frees the slot registered at the edge, but not_full uses pre-pop occupancy, so there is no same-cycle push. This has no comb path from m_tready to s_tready.
- Swap latency from cfg_valid with the system idle: DRAIN 1 cycle, SWAP 1 cycle, first beat on the new route accepted in cycle 3.

## Configuration
- DROUTE_CNT_EN defined:
  - Adds port m_beat_cnt, out, NUM_OUT*32: per-output count of m handshakes.
  - Counters wrap at 2^32 and clear on reset and in SWAP.
- DROUTE_CNT_EN undefined: port and counters absent; all other behaviour is identical.

## Structure
- Package droute_pkg: FSM state enum (RUN/DRAIN/SWAP), SEL_W derivation function, route-field unpack function, and the counter width constant 32.
- Sub-module droute_skid: a 2-entry AXI-S skid FIFO of DWIDTH+1 bits, instantiated NUM_OUT times.

## Test plan
- Route out0<-in2, out1<-in0. Drive 4 beats on each input, data 0x10..0x13 and 0x20..0x23, last on beat 4. Expect the same order on out0/out1, each 1 cycle after its fire, and tlast on beat 4.
- Broadcast in1 -> out0, out3, out5, with m_tready[3] low for 5 cycles. Expect in1 to stall after 2 beats; all three outputs eventually receive identical sequences 0..7.
- Reconfigure mid-packet: in0 is 3 beats into an 8-beat packet when cfg_valid rises. Expect the remaining 5 beats delivered on the old route, cfg_ready pulsed after the skids drain, and the next packet on the new route.
- Disabled and invalid select: field en=0, and field idx=7 with NUM_IN=5. Expect m_tvalid=0 on both outputs and s_tready=0 for the unrouted inputs with s_tvalid high.
- Assert rst_n low with 2 beats buffered. Expect m_tvalid=0 and busy=0 immediately, and act_route=0 after release.
- With DROUTE_CNT_EN: send 10 beats on out2. Expect m_beat_cnt[2]=10, then 0 after a swap.

Source files
------------

// File: rtl/droute_pkg.sv
// Shared types and helpers for the droute_xbar crossbar: FSM states, select-field decoding, counter width.
package droute_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

    localparam int CNT_W = 32;

    function automatic int sel_width(input int num_in);
        return $clog2(num_in) + 1;
    endfunction

    // A field routes only when enabled and its index names an existing input.
    function automatic logic field_routed(input logic [7:0] f, input int sw, input int num_in);
        logic [7:0] mask;
        logic [7:0] sh;
        mask = (8'd1 << (sw - 1)) - 8'd1;
        sh   = f >> (sw - 1);
        return sh[0] && (int'(f & mask) < num_in);
    endfunction

    function automatic logic [7:0] field_idx(input logic [7:0] f, input int sw);
        logic [7:0] mask;
        mask = (8'd1 << (sw - 1)) - 8'd1;
        return f & mask;
    endfunction

endpackage

// File: rtl/droute_skid.sv
// Two-entry skid FIFO with registered head; output valid one cycle after a write.
// Latency 1 cycle; space reflects pre-pop occupancy so write acceptance never depends on rd_rdy.
module droute_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         space,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);

    logic [1:0]   cnt;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         wr;
    logic         rd;

    assign space  = (cnt != 2'd2);
    assign rd_vld = (cnt != 2'd0);
    assign rd_dat = head;
    assign wr     = wr_vld & space;
    assign rd     = rd_vld & rd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case (cnt)
                2'd0: if (wr) begin
                    head <= wr_dat;
                    cnt  <= 2'd1;
                end
                2'd1: begin
                    if (wr && rd) begin
                        head <= wr_dat;
                    end else if (wr) begin
                        tail <= wr_dat;
                        cnt  <= 2'd2;
                    end else if (rd) begin
                        cnt  <= 2'd0;
                    end
                end
                2'd2: if (rd) begin
                    head <= tail;
                    cnt  <= 2'd1;
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/droute_xbar.sv
// AXI-Stream crossbar NUM_IN->NUM_OUT with packet-safe reconfiguration and broadcast; optional DROUTE_CNT_EN beat counters.
// Latency 1 cycle input fire to m_tvalid; an input is ready only when every routed output skid has space.
module droute_xbar
    import droute_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int NUM_OUT = 8,
    parameter int DWIDTH  = 1536,
    parameter int SEL_W   = sel_width(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_OUT*SEL_W-1:0]  cfg_route,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [NUM_IN*DWIDTH-1:0]  s_tdata,
    input  logic [NUM_IN-1:0]         s_tvalid,
    input  logic [NUM_IN-1:0]         s_tlast,
    output logic [NUM_IN-1:0]         s_tready,
    output logic [NUM_OUT*DWIDTH-1:0] m_tdata,
    output logic [NUM_OUT-1:0]        m_tvalid,
    output logic [NUM_OUT-1:0]        m_tlast,
    input  logic [NUM_OUT-1:0]        m_tready,
    output logic                      busy
`ifdef DROUTE_CNT_EN
    ,
    output logic [NUM_OUT*CNT_W-1:0]  m_beat_cnt
`endif
);

    state_t                   state;
    logic [NUM_OUT*SEL_W-1:0] act_route;
    logic [NUM_IN-1:0]        in_pkt;
    logic [NUM_IN-1:0]        gate;
    logic [NUM_IN-1:0]        fire;
    logic [NUM_IN-1:0]        rt_any;
    logic [NUM_IN-1:0]        rt_blk;
    logic [NUM_OUT-1:0]       routed;
    logic [NUM_OUT-1:0]       space;
    logic [NUM_OUT-1:0]       push;
    logic [7:0]               src      [NUM_OUT];
    logic [DWIDTH:0]          skid_in  [NUM_OUT];
    logic [DWIDTH:0]          skid_out [NUM_OUT];

    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            routed[o] = field_routed(8'(act_route[o*SEL_W +: SEL_W]), SEL_W, NUM_IN);
            src[o]    = field_idx(8'(act_route[o*SEL_W +: SEL_W]), SEL_W);
        end
    end

    always_comb begin
        case (state)
            RUN:     gate = '1;
            DRAIN:   gate = in_pkt;
            default: gate = '0;
        endcase
    end

    // Ready is the AND of space across every output fed by the input, so a broadcast beat lands everywhere or nowhere.
    always_comb begin
        rt_any = '0;
        rt_blk = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                if (routed[o] && src[o] == 8'(i)) begin
                    rt_any[i] = 1'b1;
                    if (!space[o]) rt_blk[i] = 1'b1;
                end
            end
        end
    end

    assign s_tready = gate & rt_any & ~rt_blk;
    assign fire     = s_tvalid & s_tready;

    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            push[o]    = 1'b0;
            skid_in[o] = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (routed[o] && src[o] == 8'(i)) begin
                    push[o]    = fire[i];
                    skid_in[o] = {s_tlast[i], s_tdata[i*DWIDTH +: DWIDTH]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            act_route <= '0;
            in_pkt    <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (fire[i]) in_pkt[i] <= !s_tlast[i];
            end
            case (state)
                RUN:   if (cfg_valid) state <= DRAIN;
                DRAIN: if (!(|in_pkt) && !(|m_tvalid)) state <= SWAP;
                SWAP: begin
                    act_route <= cfg_route;
                    state     <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign cfg_ready = (state == SWAP);
    assign busy      = (|in_pkt) | (|m_tvalid);

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        droute_skid #(.W(DWIDTH + 1)) u_skid (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_vld (push[o]),
            .wr_dat (skid_in[o]),
            .space  (space[o]),
            .rd_vld (m_tvalid[o]),
            .rd_dat (skid_out[o]),
            .rd_rdy (m_tready[o])
        );
        assign m_tlast[o]                    = skid_out[o][DWIDTH];
        assign m_tdata[o*DWIDTH +: DWIDTH]   = skid_out[o][DWIDTH-1:0];
    end

`ifdef DROUTE_CNT_EN
    logic [CNT_W-1:0] beat_cnt [NUM_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_OUT; o++) beat_cnt[o] <= '0;
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                if (state == SWAP)                  beat_cnt[o] <= '0;
                else if (m_tvalid[o] && m_tready[o]) beat_cnt[o] <= beat_cnt[o] + 1'b1;
            end
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_cnt
        assign m_beat_cnt[o*CNT_W +: CNT_W] = beat_cnt[o];
    end
`endif

endmodule

// File: tb/tb_droute_xbar.sv
// Directed self-checking bench for droute_xbar: routing, broadcast backpressure, packet-safe swap, disabled selects, reset.
module tb_droute_xbar;

    localparam int NI = 5;
    localparam int NO = 8;
    localparam int DW = 16;
    localparam int SW = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NO*SW-1:0]   cfg_route;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [NI*DW-1:0]   s_tdata;
    logic [NI-1:0]      s_tvalid;
    logic [NI-1:0]      s_tlast;
    logic [NI-1:0]      s_tready;
    logic [NO*DW-1:0]   m_tdata;
    logic [NO-1:0]      m_tvalid;
    logic [NO-1:0]      m_tlast;
    logic [NO-1:0]      m_tready;
    logic               busy;
`ifdef DROUTE_CNT_EN
    logic [NO*32-1:0]   m_beat_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    droute_xbar #(.NUM_IN(NI), .NUM_OUT(NO), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_route (cfg_route),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .busy      (busy)
`ifdef DROUTE_CNT_EN
        ,
        .m_beat_cnt(m_beat_cnt)
`endif
    );

    function automatic logic [SW-1:0] fld(input logic en, input logic [2:0] idx);
        return {en, idx};
    endfunction

    task automatic do_swap(input logic [NO*SW-1:0] r, output int cyc);
        @(negedge clk);
        cfg_route = r;
        cfg_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!cfg_ready && cyc < 40);
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_timeout: cfg_ready=%b after %0d cycles, required 1", cfg_ready, cyc);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({s_tready, m_tvalid, m_tlast, cfg_ready, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: s_tready=%b m_tvalid=%b m_tlast=%b cfg_ready=%b busy=%b, required all 0",
                     s_tready, m_tvalid, m_tlast, cfg_ready, busy);
        end
        n_checks++;
        if (m_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: m_tdata=%h, required 0", m_tdata);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        s_tvalid = '1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (s_tready !== '0 || m_tvalid !== '0) begin
            n_fail++;
            $display("FAIL reset_route_off: s_tready=%b m_tvalid=%b, required 0/0", s_tready, m_tvalid);
        end
        s_tvalid = '0;
    endtask

    task automatic test_route;
        logic [NO*SW-1:0] r;
        int cyc;
        r = '0;
        r[0*SW +: SW] = fld(1'b1, 3'd2);
        r[1*SW +: SW] = fld(1'b1, 3'd0);
        do_swap(r, cyc);
        n_checks++;
        if (cyc != 2) begin
            n_fail++;
            $display("FAIL swap_latency: cfg_ready after %0d cycles, required 2", cyc);
        end
        n_checks++;
        if (s_tready !== '0) begin
            n_fail++;
            $display("FAIL swap_gate: s_tready=%b during swap, required 0", s_tready);
        end
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if ({m_tvalid[0], m_tlast[0], m_tdata[0*DW +: DW]} !== {1'b1, (k == 4), 16'(16'h10 + k - 1)}) begin
                    n_fail++;
                    $display("FAIL route_out0 beat %0d: vld/last/data=%b/%b/%h, required 1/%b/%h",
                             k - 1, m_tvalid[0], m_tlast[0], m_tdata[0*DW +: DW], (k == 4), 16'h10 + k - 1);
                end
                n_checks++;
                if ({m_tvalid[1], m_tlast[1], m_tdata[1*DW +: DW]} !== {1'b1, (k == 4), 16'(16'h20 + k - 1)}) begin
                    n_fail++;
                    $display("FAIL route_out1 beat %0d: vld/last/data=%b/%b/%h, required 1/%b/%h",
                             k - 1, m_tvalid[1], m_tlast[1], m_tdata[1*DW +: DW], (k == 4), 16'h20 + k - 1);
                end
            end
            if (k < 4) begin
                s_tvalid[2] = 1'b1;
                s_tvalid[0] = 1'b1;
                s_tdata[2*DW +: DW] = 16'(16'h10 + k);
                s_tdata[0*DW +: DW] = 16'(16'h20 + k);
                s_tlast[2] = (k == 3);
                s_tlast[0] = (k == 3);
                n_checks++;
                if (s_tready[2:0] !== 3'b101) begin
                    n_fail++;
                    $display("FAIL route_ready beat %0d: s_tready[2:0]=%b, required 101", k, s_tready[2:0]);
                end
            end else begin
                s_tvalid = '0;
                s_tlast  = '0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL route_idle: m_tvalid=%b busy=%b, required 0/0", m_tvalid, busy);
        end
    endtask

    task automatic test_broadcast;
        logic [NO*SW-1:0] r;
        logic [DW-1:0] q0[$];
        logic [DW-1:0] q3[$];
        logic [DW-1:0] q5[$];
        int cyc;
        int idx;
        int stall_fires;
        r = '0;
        r[0*SW +: SW] = fld(1'b1, 3'd1);
        r[3*SW +: SW] = fld(1'b1, 3'd1);
        r[5*SW +: SW] = fld(1'b1, 3'd1);
        do_swap(r, cyc);
        idx = 0;
        stall_fires = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            m_tready[3] = (c >= 5);
            s_tvalid[1] = (idx < 8);
            s_tdata[1*DW +: DW] = 16'(idx);
            s_tlast[1] = (idx == 7);
            if (m_tvalid[0] && m_tready[0]) q0.push_back(m_tdata[0*DW +: DW]);
            if (m_tvalid[3] && m_tready[3]) q3.push_back(m_tdata[3*DW +: DW]);
            if (m_tvalid[5] && m_tready[5]) q5.push_back(m_tdata[5*DW +: DW]);
            if (c == 4) begin
                n_checks++;
                if (s_tready[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bcast_stalled: s_tready[1]=%b while out3 full, required 0", s_tready[1]);
                end
            end
            if (s_tvalid[1] && s_tready[1]) begin
                if (c < 5) stall_fires++;
                idx++;
            end
            if (q0.size() == 8 && q3.size() == 8 && q5.size() == 8) break;
        end
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = '1;
        n_checks++;
        if (stall_fires != 2) begin
            n_fail++;
            $display("FAIL bcast_stall_depth: %0d beats accepted during stall, required 2", stall_fires);
        end
        n_checks++;
        if (q0.size() != 8 || q3.size() != 8 || q5.size() != 8) begin
            n_fail++;
            $display("FAIL bcast_count: out0=%0d out3=%0d out5=%0d beats, required 8 each",
                     q0.size(), q3.size(), q5.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (q0[k] !== 16'(k) || q3[k] !== 16'(k) || q5[k] !== 16'(k)) begin
                    n_fail++;
                    $display("FAIL bcast_data beat %0d: out0=%h out3=%h out5=%h, required %h",
                             k, q0[k], q3[k], q5[k], 16'(k));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reconfig;
        logic [NO*SW-1:0] r_old;
        logic [NO*SW-1:0] r_new;
        logic [DW-1:0] q0[$];
        logic [DW-1:0] q1[$];
        int cyc;
        int idx;
        int early;
        logic req;
        logic seen;
        r_old = '0;
        r_old[0*SW +: SW] = fld(1'b1, 3'd0);
        r_new = '0;
        r_new[1*SW +: SW] = fld(1'b1, 3'd0);
        do_swap(r_old, cyc);
        idx = 0;
        early = 0;
        req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cfg_ready) begin
                seen = 1'b1;
                cfg_valid = 1'b0;
                n_checks++;
                if (idx != 8 || m_tvalid !== '0) begin
                    n_fail++;
                    $display("FAIL reconfig_drain: cfg_ready with %0d beats sent, m_tvalid=%b, required 8 and 0",
                             idx, m_tvalid);
                end
            end
            if (m_tvalid[0] && m_tready[0]) q0.push_back(m_tdata[0*DW +: DW]);
            if (m_tvalid[1] && m_tready[1]) q1.push_back(m_tdata[1*DW +: DW]);
            if (idx == 3 && !req) begin
                cfg_route = r_new;
                cfg_valid = 1'b1;
                req = 1'b1;
            end
            s_tvalid[0] = (idx < 12);
            s_tdata[0*DW +: DW] = (idx < 8) ? 16'(16'h30 + idx) : 16'(16'h40 + idx - 8);
            s_tlast[0] = (idx == 7 || idx == 11);
            if (s_tvalid[0] && s_tready[0]) begin
                if (idx >= 8 && !seen) early++;
                idx++;
            end
            if (idx == 12 && q0.size() == 8 && q1.size() == 4) break;
        end
        s_tvalid = '0;
        s_tlast  = '0;
        n_checks++;
        if (seen !== 1'b1 || early != 0) begin
            n_fail++;
            $display("FAIL reconfig_swap: cfg_ready seen=%b, new-packet beats before swap=%0d, required 1 and 0",
                     seen, early);
        end
        n_checks++;
        if (q0.size() != 8 || q1.size() != 4) begin
            n_fail++;
            $display("FAIL reconfig_count: out0=%0d out1=%0d beats, required 8 and 4", q0.size(), q1.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (q0[k] !== 16'(16'h30 + k)) begin
                    n_fail++;
                    $display("FAIL reconfig_old beat %0d: got %h, required %h", k, q0[k], 16'h30 + k);
                end
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (q1[k] !== 16'(16'h40 + k)) begin
                    n_fail++;
                    $display("FAIL reconfig_new beat %0d: got %h, required %h", k, q1[k], 16'h40 + k);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_disabled;
        logic [NO*SW-1:0] r;
        int cyc;
        r = '0;
        r[0*SW +: SW] = fld(1'b0, 3'd2);
        r[1*SW +: SW] = fld(1'b1, 3'd7);
        do_swap(r, cyc);
        s_tvalid = '1;
        s_tdata  = {NI{16'hbeef}};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (m_tvalid !== '0 || s_tready !== '0) begin
                n_fail++;
                $display("FAIL disabled cycle %0d: m_tvalid=%b s_tready=%b, required 0/0", c, m_tvalid, s_tready);
            end
        end
        s_tvalid = '0;
    endtask

    task automatic test_reset_mid;
        logic [NO*SW-1:0] r;
        int cyc;
        r = '0;
        r[0*SW +: SW] = fld(1'b1, 3'd0);
        do_swap(r, cyc);
        m_tready[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_tvalid[0] = 1'b1;
            s_tdata[0*DW +: DW] = 16'(16'h55 + k);
            s_tlast[0] = 1'b0;
        end
        @(negedge clk);
        s_tvalid = '0;
        n_checks++;
        if (m_tvalid[0] !== 1'b1 || busy !== 1'b1 || m_tdata[0*DW +: DW] !== 16'h55) begin
            n_fail++;
            $display("FAIL rst_mid_pre: m_tvalid[0]=%b busy=%b data=%h, required 1/1/0055",
                     m_tvalid[0], busy, m_tdata[0*DW +: DW]);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_tvalid !== '0 || busy !== 1'b0 || m_tdata !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: m_tvalid=%b busy=%b m_tdata=%h, required 0/0/0", m_tvalid, busy, m_tdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_tready = '1;
        s_tvalid[0] = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (s_tready !== '0 || m_tvalid !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_route: s_tready=%b m_tvalid=%b after release, required 0/0", s_tready, m_tvalid);
        end
        s_tvalid = '0;
    endtask

`ifdef DROUTE_CNT_EN
    task automatic test_counter;
        logic [NO*SW-1:0] r;
        int cyc;
        r = '0;
        r[2*SW +: SW] = fld(1'b1, 3'd3);
        do_swap(r, cyc);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s_tvalid[3] = 1'b1;
            s_tdata[3*DW +: DW] = 16'(k);
            s_tlast[3] = (k == 9);
        end
        @(negedge clk);
        s_tvalid = '0;
        s_tlast  = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (m_beat_cnt[2*32 +: 32] !== 32'd10 || m_beat_cnt[0 +: 32] !== 32'd0) begin
            n_fail++;
            $display("FAIL cnt_value: out2=%0d out0=%0d, required 10 and 0",
                     m_beat_cnt[2*32 +: 32], m_beat_cnt[0 +: 32]);
        end
        do_swap(r, cyc);
        @(negedge clk);
        n_checks++;
        if (m_beat_cnt[2*32 +: 32] !== 32'd0) begin
            n_fail++;
            $display("FAIL cnt_swap_clear: out2=%0d, required 0", m_beat_cnt[2*32 +: 32]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        cfg_route = '0;
        cfg_valid = 1'b0;
        s_tdata   = '0;
        s_tvalid  = '0;
        s_tlast   = '0;
        m_tready  = '1;
        test_reset();
        test_route();
        test_broadcast();
        test_reconfig();
        test_disabled();
        test_reset_mid();
`ifdef DROUTE_CNT_EN
        test_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
